// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: a write to FF46 copies 160 bytes from {SRC,00..9F} into OAM,
// one read per cycle, each byte written to OAM on the cycle after its read.
module oam_dma_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ADDR,
  input  logic        WR,
  input  logic [7:0]  MMIO_DATA_out,
  output logic        DMA_RD,
  output logic [15:0] DMA_RD_ADDR,
  input  logic [7:0]  DMA_DATA_in,
  output logic        OAM_WR,
  output logic [7:0]  OAM_ADDR,
  output logic [7:0]  OAM_WDATA,
  output logic        DMA_ACTIVE,
  output logic        CPU_BLOCK
);

  localparam logic [15:0] DMA_REG  = 16'hFF46;
  localparam logic [7:0]  LAST_IDX = 8'd159;

  typedef enum logic [1:0] {IDLE, START, XFER} state_t;

  state_t      state, nxt_state;
  logic [7:0]  src, nxt_src;
  logic [7:0]  idx, nxt_idx;
  logic        wp;
  logic [7:0]  widx;
  logic        trig;
  logic        rd_issue;

  // Sources in E000-FFFF alias work RAM at C000-DFFF.
  function automatic logic [7:0] fold_src(input logic [7:0] page);
    return (page >= 8'hE0) ? (page - 8'h20) : page;
  endfunction

  assign trig     = WR && (ADDR == DMA_REG);
  assign rd_issue = (state == XFER);

  always_comb begin
    nxt_state = state;
    nxt_src   = src;
    nxt_idx   = idx;
    case (state)
      IDLE: ;
      START: begin
        nxt_state = XFER;
        nxt_idx   = 8'd0;
      end
      XFER: begin
        if (idx == LAST_IDX) begin
          nxt_state = IDLE;
          nxt_idx   = 8'd0;
        end else begin
          nxt_idx = idx + 8'd1;
        end
      end
      default: nxt_state = IDLE;
    endcase
    // A new trigger always wins, including on the final issue edge.
    if (trig) begin
      nxt_state = START;
      nxt_src   = fold_src(MMIO_DATA_out);
      nxt_idx   = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      src   <= 8'd0;
      idx   <= 8'd0;
      wp    <= 1'b0;
      widx  <= 8'd0;
    end else begin
      state <= nxt_state;
      src   <= nxt_src;
      idx   <= nxt_idx;
      // Read data returns one cycle later, so the OAM write trails its read.
      wp    <= rd_issue;
      if (rd_issue) widx <= idx;
    end
  end

  assign DMA_RD      = rd_issue;
  assign DMA_RD_ADDR = rd_issue ? {src, idx} : 16'h0000;
  assign OAM_WR      = wp;
  assign OAM_ADDR    = wp ? widx : 8'h00;
  assign OAM_WDATA   = wp ? DMA_DATA_in : 8'h00;
  assign DMA_ACTIVE  = (state != IDLE) || wp;
  // HRAM and the DMA register itself stay reachable during a transfer.
  assign CPU_BLOCK   = DMA_ACTIVE && !((ADDR >= 16'hFF80) && (ADDR <= 16'hFFFE))
                       && (ADDR != DMA_REG);

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: vector table for the transfer start and CPU
// blocking, then hand-written sequences for restart, reset abort and chained triggers.
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ADDR = 16'h0000;
  logic        WR = 1'b0;
  logic [7:0]  MMIO_DATA_out = 8'h00;
  logic        DMA_RD;
  logic [15:0] DMA_RD_ADDR;
  logic [7:0]  DMA_DATA_in;
  logic        OAM_WR;
  logic [7:0]  OAM_ADDR;
  logic [7:0]  OAM_WDATA;
  logic        DMA_ACTIVE;
  logic        CPU_BLOCK;

  int tests = 0;
  int failed = 0;
  bit mix = 1'b0;
  logic [7:0] src_pend = 8'h00;

  oam_dma_ctrl dut (
    .clk(clk), .rst(rst), .ADDR(ADDR), .WR(WR), .MMIO_DATA_out(MMIO_DATA_out),
    .DMA_RD(DMA_RD), .DMA_RD_ADDR(DMA_RD_ADDR), .DMA_DATA_in(DMA_DATA_in),
    .OAM_WR(OAM_WR), .OAM_ADDR(OAM_ADDR), .OAM_WDATA(OAM_WDATA),
    .DMA_ACTIVE(DMA_ACTIVE), .CPU_BLOCK(CPU_BLOCK)
  );

  always #5 clk = ~clk;

  // Source memory: byte = low address, or high^low address when mix is set.
  always @(negedge clk)
    src_pend <= DMA_RD ? (mix ? (DMA_RD_ADDR[15:8] ^ DMA_RD_ADDR[7:0]) : DMA_RD_ADDR[7:0]) : 8'h00;
  always @(posedge clk) DMA_DATA_in <= src_pend;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [7:0]  wdata;
    logic        rd;
    logic [15:0] rd_addr;
    logic        oam_wr;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        active;
    logic        block;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] expd(input logic [7:0] s, input int i);
    logic [7:0] b;
    b = i[7:0];
    return mix ? (s ^ b) : b;
  endfunction

  task automatic trigger(input logic [7:0] page);
    ADDR = 16'hFF46; WR = 1'b1; MMIO_DATA_out = page;
    tick();
    WR = 1'b0; ADDR = 16'h0000;
  endtask

  // Checks read cycles first..last; entered at the start of the cycle issuing 'first'.
  task automatic run_reads(input logic [7:0] s, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      chk("xfer_rd", {15'd0, DMA_RD}, 16'd1);
      chk("xfer_rd_addr", DMA_RD_ADDR, {s, i[7:0]});
      if (i == 0) begin
        chk("xfer_first_no_wr", {15'd0, OAM_WR}, 16'd0);
      end else begin
        chk("xfer_oam_wr", {15'd0, OAM_WR}, 16'd1);
        chk("xfer_oam_addr", {8'd0, OAM_ADDR}, i[15:0] - 16'd1);
        chk("xfer_oam_wdata", {8'd0, OAM_WDATA}, {8'd0, expd(s, i - 1)});
      end
      chk("xfer_active", {15'd0, DMA_ACTIVE}, 16'd1);
      tick();
    end
  endtask

  task automatic tail(input logic [7:0] s);
    @(negedge clk);
    chk("tail_rd", {15'd0, DMA_RD}, 16'd0);
    chk("tail_oam_wr", {15'd0, OAM_WR}, 16'd1);
    chk("tail_oam_addr", {8'd0, OAM_ADDR}, 16'd159);
    chk("tail_oam_wdata", {8'd0, OAM_WDATA}, {8'd0, expd(s, 159)});
    chk("tail_active", {15'd0, DMA_ACTIVE}, 16'd1);
    tick();
    @(negedge clk);
    chk("done_active", {15'd0, DMA_ACTIVE}, 16'd0);
    chk("done_oam_wr", {15'd0, OAM_WR}, 16'd0);
    tick();
  endtask

  task automatic start_cycle(input string nm);
    @(negedge clk);
    chk({nm, "_start_rd"}, {15'd0, DMA_RD}, 16'd0);
    chk({nm, "_start_active"}, {15'd0, DMA_ACTIVE}, 16'd1);
    tick();
  endtask

  initial begin
    tbl[0] = '{16'h0000, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{16'hFF46, 1'b1, 8'hC1, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[2] = '{16'hFF90, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
    tbl[3] = '{16'hFE00, 1'b0, 8'h00, 1'b1, 16'hC100, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1};
    tbl[4] = '{16'hFF46, 1'b0, 8'h00, 1'b1, 16'hC101, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0};
    tbl[5] = '{16'h0000, 1'b0, 8'h00, 1'b1, 16'hC102, 1'b1, 8'h01, 8'h01, 1'b1, 1'b1};
    tbl[6] = '{16'hFFFF, 1'b0, 8'h00, 1'b1, 16'hC103, 1'b1, 8'h02, 8'h02, 1'b1, 1'b1};
    tbl[7] = '{16'hFFFE, 1'b0, 8'h00, 1'b1, 16'hC104, 1'b1, 8'h03, 8'h03, 1'b1, 1'b0};
    tbl[8] = '{16'hFF7F, 1'b0, 8'h00, 1'b1, 16'hC105, 1'b1, 8'h04, 8'h04, 1'b1, 1'b1};

    // Reset state while rst is held
    @(negedge clk);
    chk("rst_rd", {15'd0, DMA_RD}, 16'd0);
    chk("rst_oam_wr", {15'd0, OAM_WR}, 16'd0);
    chk("rst_active", {15'd0, DMA_ACTIVE}, 16'd0);
    #2 rst = 1'b0;
    tick();

    // C1 transfer start and CPU blocking from the vector table
    mix = 1'b0;
    for (int j = 0; j < 9; j++) begin
      ADDR = tbl[j].addr; WR = tbl[j].wr; MMIO_DATA_out = tbl[j].wdata;
      @(negedge clk);
      chk($sformatf("v%0d_rd", j), {15'd0, DMA_RD}, {15'd0, tbl[j].rd});
      chk($sformatf("v%0d_rd_addr", j), DMA_RD_ADDR, tbl[j].rd_addr);
      chk($sformatf("v%0d_oam_wr", j), {15'd0, OAM_WR}, {15'd0, tbl[j].oam_wr});
      chk($sformatf("v%0d_oam_addr", j), {8'd0, OAM_ADDR}, {8'd0, tbl[j].oam_addr});
      chk($sformatf("v%0d_oam_wdata", j), {8'd0, OAM_WDATA}, {8'd0, tbl[j].oam_wdata});
      chk($sformatf("v%0d_active", j), {15'd0, DMA_ACTIVE}, {15'd0, tbl[j].active});
      chk($sformatf("v%0d_block", j), {15'd0, CPU_BLOCK}, {15'd0, tbl[j].block});
      tick();
    end
    ADDR = 16'h0000; WR = 1'b0;
    run_reads(8'hC1, 6, 159);
    tail(8'hC1);

    // Echo fold (FE -> DE), then async reset at IDX=80
    trigger(8'hFE);
    start_cycle("fe");
    run_reads(8'hDE, 0, 79);
    ADDR = 16'hFE00;
    @(negedge clk);
    chk("pre_rst_rd_addr", DMA_RD_ADDR, 16'hDE50);
    #2 rst = 1'b1;
    #1;
    chk("async_rd", {15'd0, DMA_RD}, 16'd0);
    chk("async_rd_addr", DMA_RD_ADDR, 16'h0000);
    chk("async_oam_wr", {15'd0, OAM_WR}, 16'd0);
    chk("async_oam_addr", {8'd0, OAM_ADDR}, 16'h0000);
    chk("async_oam_wdata", {8'd0, OAM_WDATA}, 16'h0000);
    chk("async_active", {15'd0, DMA_ACTIVE}, 16'd0);
    chk("async_block", {15'd0, CPU_BLOCK}, 16'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("post_rst_rd", {15'd0, DMA_RD}, 16'd0);
      chk("post_rst_oam_wr", {15'd0, OAM_WR}, 16'd0);
    end
    tick();

    // Restart at IDX=50: 80 -> 90
    mix = 1'b1;
    trigger(8'h80);
    start_cycle("r80");
    run_reads(8'h80, 0, 49);
    ADDR = 16'hFF46; WR = 1'b1; MMIO_DATA_out = 8'h90;
    @(negedge clk);
    chk("restart_rd_addr", DMA_RD_ADDR, 16'h8032);
    chk("restart_oam_addr", {8'd0, OAM_ADDR}, 16'd49);
    chk("restart_oam_wdata", {8'd0, OAM_WDATA}, 16'h00B1);
    tick();
    WR = 1'b0; ADDR = 16'h0000;
    @(negedge clk);
    chk("restart_start_rd", {15'd0, DMA_RD}, 16'd0);
    chk("restart_pending_wr", {15'd0, OAM_WR}, 16'd1);
    chk("restart_pending_addr", {8'd0, OAM_ADDR}, 16'd50);
    chk("restart_pending_data", {8'd0, OAM_WDATA}, 16'h00B2);
    tick();
    run_reads(8'h90, 0, 159);
    tail(8'h90);

    // Trigger coincident with the IDX=159 issue edge
    trigger(8'hC1);
    start_cycle("c1m");
    run_reads(8'hC1, 0, 158);
    ADDR = 16'hFF46; WR = 1'b1; MMIO_DATA_out = 8'h12;
    @(negedge clk);
    chk("last_rd_addr", DMA_RD_ADDR, 16'hC19F);
    chk("last_oam_addr", {8'd0, OAM_ADDR}, 16'd158);
    chk("last_oam_wdata", {8'd0, OAM_WDATA}, 16'h005F);
    tick();
    WR = 1'b0; ADDR = 16'h0000;
    @(negedge clk);
    chk("chain_start_rd", {15'd0, DMA_RD}, 16'd0);
    chk("chain_oam_wr", {15'd0, OAM_WR}, 16'd1);
    chk("chain_oam_addr", {8'd0, OAM_ADDR}, 16'd159);
    chk("chain_oam_wdata", {8'd0, OAM_WDATA}, 16'h005E);
    chk("chain_active", {15'd0, DMA_ACTIVE}, 16'd1);
    tick();
    run_reads(8'h12, 0, 159);
    tail(8'h12);

    // Idle: nothing blocked
    ADDR = 16'hFE00;
    @(negedge clk); chk("idle_block_fe00", {15'd0, CPU_BLOCK}, 16'd0);
    ADDR = 16'hFFFF;
    @(negedge clk); chk("idle_block_ffff", {15'd0, CPU_BLOCK}, 16'd0);
    ADDR = 16'hC000;
    @(negedge clk); chk("idle_block_c000", {15'd0, CPU_BLOCK}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
